// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter: fixed-priority or round-robin selection with locked transfers,
// a burst hold limit and a default master. All outputs are registered.
`timescale 1ns/1ps
module ahb_arbiter_rr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [NUM_MASTERS-1:0]         hreq,
  input  logic [NUM_MASTERS-1:0]         hlock,
  input  logic                           hready,
  input  logic [1:0]                     htrans,
  input  logic                           arb_mode,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
  output logic                           hmastlock
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  localparam int unsigned SUM_W = IDX_W + 1;

  localparam logic [IDX_W-1:0] DEF_IDX     = IDX_W'(DEFAULT_MASTER);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_MASTERS - 1);
  localparam logic [SUM_W-1:0] NUM_SUM     = SUM_W'(NUM_MASTERS);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MAX_HOLD - 1);
  localparam logic [1:0]       HTRANS_IDLE = 2'b00;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_HELD   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       master_q, master_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic                   mlock_q, mlock_d;

  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       fix_win;
  logic [IDX_W-1:0]       rr_win;
  logic [IDX_W-1:0]       rr_cand;
  logic [SUM_W-1:0]       rr_sum;
  logic                   rr_found;
  logic                   any_req;
  logic [IDX_W-1:0]       winner;

  // Owner index decoded from the one-hot grant
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[IDX_W'(i)]) owner = IDX_W'(i);
    end
  end

  // Winner selection: highest index in fixed mode, first requester at/after pointer in RR
  always_comb begin
    fix_win  = DEF_IDX;
    rr_win   = DEF_IDX;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (hreq[IDX_W'(i)]) fix_win = IDX_W'(i);
    end
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      rr_sum = {1'b0, ptr_q} + SUM_W'(k);
      if (rr_sum >= NUM_SUM) rr_sum = rr_sum - NUM_SUM;
      rr_cand = IDX_W'(rr_sum);
      if (!rr_found && hreq[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
    any_req = |hreq;
    if (!any_req)      winner = DEF_IDX;
    else if (arb_mode) winner = rr_win;
    else               winner = fix_win;
  end

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_OPEN;
      grant_q  <= NUM_MASTERS'(1) << DEF_IDX;
      ptr_q    <= DEF_IDX;
      hold_q   <= '0;
      master_q <= DEF_IDX;
      mlock_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
    end
  end

  // Next state: lock beats hold beats re-arbitration, only on hready cycles
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (hready) begin
      if (hreq[owner] && hlock[owner]) begin
        state_d = ST_LOCKED;
      end else if (hreq[owner] && (htrans != HTRANS_IDLE) && (hold_q < HOLD_LAST)) begin
        state_d = ST_HELD;
        hold_d  = hold_q + CNT_W'(1);
      end else begin
        state_d = ST_OPEN;
        hold_d  = '0;
        grant_d = NUM_MASTERS'(1) << winner;
        if (arb_mode && any_req) begin
          ptr_d = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
        end
      end
    end
  end

  // Address-phase owner and lock follow the grant by one hready cycle
  always_comb begin
    master_d = master_q;
    mlock_d  = mlock_q;
    if (hready) begin
      master_d = owner;
      mlock_d  = hlock[owner];
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = master_q;
  assign hmastlock = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a behavioural arbitration model.
`timescale 1ns/1ps
module tb_ahb_arbiter_rr;

  localparam int N   = 4;
  localparam int DEF = 2;
  localparam int MH  = 4;

  logic         hclk = 1'b0;
  logic         hresetn;
  logic [N-1:0] hreq;
  logic [N-1:0] hlock;
  logic         hready;
  logic [1:0]   htrans;
  logic         arb_mode;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int checks = 0;
  int errors = 0;

  // Model state: who owns the bus, how long it has held, RR pointer, registered outputs
  int m_owner, m_hold, m_ptr, m_master;
  logic m_mlock;

  always #5 hclk = ~hclk;

  ahb_arbiter_rr #(
    .NUM_MASTERS   (N),
    .DEFAULT_MASTER(DEF),
    .MAX_HOLD      (MH)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hreq     (hreq),
    .hlock    (hlock),
    .hready   (hready),
    .htrans   (htrans),
    .arb_mode (arb_mode),
    .hgrant   (hgrant),
    .hmaster  (hmaster),
    .hmastlock(hmastlock)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic       mode;
    logic       ready;
    logic [3:0] g;
    int         m;
    logic       ml;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner  = DEF;
    m_hold   = 0;
    m_ptr    = DEF;
    m_master = DEF;
    m_mlock  = 1'b0;
  endfunction

  function automatic void model_step();
    int o;
    int c;
    o = m_owner;
    if (!hready) return;
    m_master = o;
    m_mlock  = hlock[o[1:0]];
    if (hreq[o[1:0]] && hlock[o[1:0]]) begin
      // locked owner keeps the bus
    end else if (hreq[o[1:0]] && htrans != 2'b00 && m_hold < MH - 1) begin
      m_hold++;
    end else begin
      m_hold = 0;
      if (hreq == '0) begin
        m_owner = DEF;
      end else if (!arb_mode) begin
        for (int i = 0; i < N; i++) if (hreq[i]) m_owner = i;
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          c = (m_ptr + k) % N;
          if (hreq[c]) m_owner = c;
        end
        m_ptr = (m_owner + 1) % N;
      end
    end
  endfunction

  task automatic set_in(input logic [3:0] rq, input logic [3:0] lk, input logic [1:0] tr,
                        input logic md, input logic rd);
    hreq = rq; hlock = lk; htrans = tr; arb_mode = md; hready = rd;
  endtask

  task automatic tick();
    model_step();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = 4'b0001 << m_owner;
    chk("rand_grant",  32'(hgrant),    32'(eg));
    chk("rand_master", 32'(hmaster),   32'(m_master));
    chk("rand_mlock",  32'(hmastlock), 32'(m_mlock));
    chk("rand_onehot", 32'($onehot(hgrant)), 32'(1));
  endtask

  // Asynchronous reset pulse from mid-cycle, outputs checked while reset is held
  task automatic do_reset();
    hresetn = 1'b0;
    #1;
    chk("rst_grant",  32'(hgrant),    32'h4);
    chk("rst_master", 32'(hmaster),   32'd2);
    chk("rst_mlock",  32'(hmastlock), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0100, 2, 1'b0};
    tbl[1]  = '{4'b0101, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0100, 2, 1'b0};
    tbl[2]  = '{4'b0101, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0100, 2, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0100, 2, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b1000, 2, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0001, 3, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0010, 0, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0100, 1, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b1000, 2, 1'b0};
    tbl[9]  = '{4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 4'b1000, 2, 1'b0};
    tbl[10] = '{4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 4'b1000, 2, 1'b0};
    tbl[11] = '{4'b0001, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0001, 3, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 4'b0100, 0, 1'b0};

    hresetn = 1'b1;
    set_in(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    #1 hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    chk("por_grant",  32'(hgrant),    32'h4);
    chk("por_master", 32'(hmaster),   32'd2);
    chk("por_mlock",  32'(hmastlock), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    model_reset();

    // Directed table: default, fixed priority, round-robin rotation, wait states
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].mode, tbl[i].ready);
      tick();
      chk("tbl_grant",  32'(hgrant),    32'(tbl[i].g));
      chk("tbl_master", 32'(hmaster),   32'(tbl[i].m));
      chk("tbl_mlock",  32'(hmastlock), 32'(tbl[i].ml));
    end

    // Hold limit, then a lone requester that keeps being re-granted
    do_reset();
    set_in(4'b0011, 4'b0000, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_keep0", 32'(hgrant), 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_keep1", 32'(hgrant), 32'h2);
    end
    tick();
    chk("hold_back0", 32'(hgrant), 32'h1);
    set_in(4'b0001, 4'b0000, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lone_keep", 32'(hgrant), 32'h1);
    end

    // Locked master 1 is never preempted by master 3
    do_reset();
    set_in(4'b0010, 4'b0010, 2'b11, 1'b0, 1'b1);
    tick();
    chk("lock_first_grant", 32'(hgrant),    32'h2);
    chk("lock_first_mlock", 32'(hmastlock), 32'd0);
    set_in(4'b1010, 4'b0010, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lock_grant", 32'(hgrant),    32'h2);
      chk("lock_mlock", 32'(hmastlock), 32'd1);
    end
    set_in(4'b1000, 4'b0000, 2'b11, 1'b0, 1'b1);
    tick();
    chk("unlock_grant",  32'(hgrant),    32'h8);
    chk("unlock_master", 32'(hmaster),   32'd1);
    chk("unlock_mlock",  32'(hmastlock), 32'd0);

    // Wait states defer a grant change to the first ready edge
    do_reset();
    set_in(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1);
    tick();
    tick();
    chk("ws_pre_grant",  32'(hgrant),  32'h1);
    chk("ws_pre_master", 32'(hmaster), 32'd0);
    set_in(4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_frz_grant",  32'(hgrant),  32'h1);
      chk("ws_frz_master", 32'(hmaster), 32'd0);
    end
    hready = 1'b1;
    tick();
    chk("ws_rel_grant",  32'(hgrant),  32'h8);
    chk("ws_rel_master", 32'(hmaster), 32'd0);
    tick();
    chk("ws_next_master", 32'(hmaster), 32'd3);

    // Random traffic against the model, with occasional mid-run resets
    do_reset();
    arb_mode = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      hreq   = 4'($urandom);
      hlock  = 4'($urandom) & 4'($urandom);
      htrans = 2'($urandom_range(0, 3));
      hready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) arb_mode = ~arb_mode;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick();
        check_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_rr.md
# ahb_arbiter_rr

Parametrised AHB bus arbiter with selectable fixed-priority or round-robin arbitration, locked-transfer support, a burst hold limit and a default master. It sits between the AHB masters and the shared AHB bus in front of the APB bridge. It drives the one-hot grant vector, plus the registered `hmaster` and `hmastlock` used by the address/data mux and the slaves.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of masters. Must be 2 or more.
- `DEFAULT_MASTER`, default 0: index granted when nobody requests, and at reset. Must be less than `NUM_MASTERS`.
- `MAX_HOLD`, default 16: maximum consecutive owner-held arbitration points before forced re-arbitration. Must be 2 or more.

Ports:
- `hclk`  in  1  AHB clock; the only clock.
- `hresetn`  in  1  reset, asynchronous, active-low.
- `hreq`  in  NUM_MASTERS  request per master.
- `hlock`  in  NUM_MASTERS  locked-transfer request per master.
- `hready`  in  1  bus ready; arbitration points occur only when this is 1.
- `htrans`  in  2  current bus transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `arb_mode`  in  1  0 = fixed priority (highest index wins), 1 = round-robin. Sampled at each arbitration point.
- `hgrant`  out  NUM_MASTERS  one-hot grant, registered.
- `hmaster`  out  $clog2(NUM_MASTERS)  index of the current address-phase owner, registered.
- `hmastlock`  out  1  the current address-phase transfer is locked, registered.

## Operation
- **Owner**: the index of the set bit in `hgrant`. `hgrant` is exactly one-hot at all times after reset, never all-zero.
- **Hold counter**: width $clog2(MAX_HOLD+1).
- **Reset values**:
  - `hgrant` = one-hot(`DEFAULT_MASTER`)
  - `hmaster` = `DEFAULT_MASTER`
  - `hmastlock` = 0
  - hold counter = 0
  - round-robin pointer = `DEFAULT_MASTER`
  - state = OPEN
- **States**: OPEN, HELD, LOCKED. Every transition happens only on a cycle with `hready`=1. When `hready`=0, all state, counters, `hgrant`, `hmaster` and `hmastlock` hold their values.
- **Evaluation order**, on each `hready`=1 cycle, first match wins:
  - **1. LOCKED**: if `hreq[owner]` and `hlock[owner]`:
    - keep the grant;
    - state goes to LOCKED;
    - the hold counter is frozen;
    - no preemption, regardless of `MAX_HOLD` or other requests.
  - **2. HELD**: if `hreq[owner]`, `htrans` is not IDLE, and hold counter < `MAX_HOLD`-1:
    - keep the grant;
    - state goes to HELD;
    - hold counter increments by 1.
  - **3. Arbitrate**: in all other cases:
    - select a winner;
    - `hgrant` <= one-hot(winner);
    - hold counter <= 0;
    - state goes to OPEN.
- **Winner selection**:
  - **No requests**: winner is `DEFAULT_MASTER`.
  - **Fixed mode** (`arb_mode`=0): the highest-index requester wins.
  - **Round-robin mode** (`arb_mode`=1): search upward from the pointer, wrapping from `NUM_MASTERS`-1 to 0. The first requester found wins. The pointer is then set to (winner+1) mod `NUM_MASTERS`. The pointer updates only on an arbitration with at least one requester.
- **Lone requester**: if the owner is the only requester when the limit forces arbitration, it is re-granted and its counter restarts.
- **Mode switch**: changing `arb_mode` takes effect at the next arbitration. It never preempts a HELD or LOCKED owner.

## Timing
- **Grant latency**: a request sampled on an OPEN `hready`=1 cycle n appears on `hgrant` at edge n+1.
- **hmaster / hmastlock**: on every `hready`=1 edge, `hmaster` <= the index of the current `hgrant` and `hmastlock` <= `hlock[owner]`. `hmaster` therefore lags `hgrant` by one `hready`-qualified cycle, which aligns with the AHB address-phase handover.
- **Hold limit**: with competing requests, an owner keeps the bus for at most `MAX_HOLD` consecutive `hready`=1 cycles when unlocked.
- **Wait states**: during an `hready`=0 stretch, grant changes are deferred to the first edge with `hready`=1.
- **Reset mid-transfer**: outputs return to their reset values asynchronously. Normal operation resumes on the first edge after deassertion.

## Test plan
- **Reset/default**: NUM_MASTERS=4, DEFAULT_MASTER=2, `hreq`=0000, `hready`=1.
  - During reset: `hgrant`=0100, `hmaster`=2, `hmastlock`=0.
  - After reset: these values are unchanged.
- **Fixed priority**: `arb_mode`=0, `hreq`=0101, `htrans`=IDLE.
  - `hgrant`=0100 after 1 edge.
  - `hmaster`=2 after 2 edges.
- **Round-robin fairness**: `arb_mode`=1, `hreq`=1111, `htrans`=IDLE.
  - Successive grants: 0001, 0010, 0100, 1000, 0001.
- **Hold limit**: MAX_HOLD=4, owner 0 requesting with `htrans`=SEQ, `hreq`=0011, `arb_mode`=1.
  - Master 0 holds for 4 `hready` cycles.
  - Then `hgrant`=0010.
- **Lock**: master 1 has `hreq`=`hlock`=1 for 20 cycles, master 3 also requesting, `htrans`=SEQ.
  - `hgrant`=0010 throughout.
  - `hmastlock`=1 from the second edge.
  - Grant moves to 1000 on the first edge after `hlock[1]` drops.
- **Wait states**: `hready`=0 for 3 cycles while `hreq` changes from 0001 to 1000.
  - `hgrant` and `hmaster` are frozen.
  - `hgrant`=1000 on the first `hready`=1 edge.
